// File: rtl/cond_resolve_unit.sv
// rtl/cond_resolve_unit.sv - pipelined branch-condition resolver with redirect and stats
module cond_resolve_unit #(
  parameter int DBITS        = 32,
  parameter int OP_BIT_WIDTH = 4,
  parameter int STAGES       = 2,
  parameter int TAG_BITS     = 4,
  parameter int CNT_BITS     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_BIT_WIDTH-1:0] in_op2,
  input  logic [DBITS-1:0]    in_a,
  input  logic [DBITS-1:0]    in_b,
  input  logic                in_pred_taken,
  input  logic [DBITS-1:0]    in_target,
  input  logic [DBITS-1:0]    in_fallthru,
  input  logic [TAG_BITS-1:0] in_tag,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_cond,
  output logic                out_illegal,
  output logic                out_redirect,
  output logic [DBITS-1:0]    out_redirect_pc,
  output logic [TAG_BITS-1:0] out_tag,
  input  logic                stats_clr,
  output logic [CNT_BITS-1:0] resolved_cnt,
  output logic [CNT_BITS-1:0] redirect_cnt
);

  logic signed [DBITS-1:0] sa, sb;
  logic                    base, c0_cond, c0_illegal, c0_redirect;
  logic [DBITS-1:0]        c0_pc;

  logic [STAGES-1:0]       vld, ld;
  logic [STAGES-1:0]       cond_r, illegal_r, redir_r;
  logic [DBITS-1:0]        pc_r  [STAGES];
  logic [TAG_BITS-1:0]     tag_r [STAGES];
  logic                    full;
  logic                    hs;

  assign sa = in_a;
  assign sb = in_b;

  // Decode the condition code and resolve taken/redirect for the presented request
  always_comb begin
    base       = 1'b0;
    c0_illegal = 1'b0;
    case (in_op2[2:0])
      3'b000:  base = 1'b0;
      3'b001:  base = (sa == sb);
      3'b010:  base = (sa < sb);
      3'b011:  base = (sa <= sb);
      3'b101:  base = (in_a == '0);
      3'b110:  base = in_a[DBITS-1];
      3'b111:  base = in_a[DBITS-1] | (in_a == '0);
      default: c0_illegal = 1'b1;
    endcase
    // Reserved codes never invert: they always report not-taken
    c0_cond     = c0_illegal ? 1'b0 : (base ^ in_op2[3]);
    c0_redirect = c0_illegal ? in_pred_taken : (c0_cond ^ in_pred_taken);
    c0_pc       = c0_cond ? in_target : in_fallthru;
  end

  // Elastic load enables: a stage loads if it, or any stage after it, has room or the sink drains
  always_comb begin
    ld   = '0;
    full = 1'b1;
    for (int k = STAGES - 1; k >= 0; k--) begin
      full  = full & vld[k];
      ld[k] = out_ready | ~full;
    end
  end

  assign in_ready = ld[0] & ~flush;

  // Pipeline registers: stage 0 captures the resolved result, later stages just carry it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld       <= '0;
      cond_r    <= '0;
      illegal_r <= '0;
      redir_r   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        pc_r[k]  <= '0;
        tag_r[k] <= '0;
      end
    end else begin
      if (ld[0]) begin
        vld[0]       <= in_valid & ~flush;
        cond_r[0]    <= c0_cond;
        illegal_r[0] <= c0_illegal;
        redir_r[0]   <= c0_redirect;
        pc_r[0]      <= c0_pc;
        tag_r[0]     <= in_tag;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (ld[k]) begin
          vld[k]       <= vld[k-1];
          cond_r[k]    <= cond_r[k-1];
          illegal_r[k] <= illegal_r[k-1];
          redir_r[k]   <= redir_r[k-1];
          pc_r[k]      <= pc_r[k-1];
          tag_r[k]     <= tag_r[k-1];
        end
      end
      // Flush only kills valid bits; stale data is harmless once invalid
      if (flush) vld <= '0;
    end
  end

  assign out_valid       = vld[STAGES-1];
  assign out_cond        = cond_r[STAGES-1];
  assign out_illegal     = illegal_r[STAGES-1];
  assign out_redirect    = redir_r[STAGES-1];
  assign out_redirect_pc = pc_r[STAGES-1];
  assign out_tag         = tag_r[STAGES-1];

  assign hs = out_valid & out_ready & ~flush;

  // Saturating statistics; clear wins over a coincident handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resolved_cnt <= '0;
      redirect_cnt <= '0;
    end else if (stats_clr) begin
      resolved_cnt <= '0;
      redirect_cnt <= '0;
    end else if (hs) begin
      if (resolved_cnt != '1) resolved_cnt <= resolved_cnt + CNT_BITS'(1);
      if (out_redirect && (redirect_cnt != '1)) redirect_cnt <= redirect_cnt + CNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_cond_resolve_unit.sv
// tb/tb_cond_resolve_unit.sv - randomized self-checking bench for cond_resolve_unit
module tb_cond_resolve_unit;

  localparam int DBITS  = 32;
  localparam int OPW    = 4;
  localparam int STAGES = 2;
  localparam int TAGB   = 4;
  localparam int CNTB   = 4;
  localparam int CMAX   = 15;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [OPW-1:0]    in_op2 = '0;
  logic [DBITS-1:0]  in_a = '0;
  logic [DBITS-1:0]  in_b = '0;
  logic              in_pred_taken = 1'b0;
  logic [DBITS-1:0]  in_target = '0;
  logic [DBITS-1:0]  in_fallthru = '0;
  logic [TAGB-1:0]   in_tag = '0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_cond;
  logic              out_illegal;
  logic              out_redirect;
  logic [DBITS-1:0]  out_redirect_pc;
  logic [TAGB-1:0]   out_tag;
  logic              stats_clr = 1'b0;
  logic [CNTB-1:0]   resolved_cnt;
  logic [CNTB-1:0]   redirect_cnt;

  typedef struct {
    logic             cond;
    logic             illegal;
    logic             redirect;
    logic [DBITS-1:0] pc;
    logic [TAGB-1:0]  tag;
  } res_t;

  res_t q[$];
  res_t exp_r;
  int   vectors = 0;
  int   miscompares = 0;
  int   mres = 0;
  int   mred = 0;
  logic last_in_hs = 1'b0;
  logic exp_rdy;
  logic ohs;

  cond_resolve_unit #(
    .DBITS(DBITS), .OP_BIT_WIDTH(OPW), .STAGES(STAGES), .TAG_BITS(TAGB), .CNT_BITS(CNTB)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op2(in_op2),
    .in_a(in_a), .in_b(in_b), .in_pred_taken(in_pred_taken),
    .in_target(in_target), .in_fallthru(in_fallthru), .in_tag(in_tag),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_cond(out_cond),
    .out_illegal(out_illegal), .out_redirect(out_redirect),
    .out_redirect_pc(out_redirect_pc), .out_tag(out_tag),
    .stats_clr(stats_clr), .resolved_cnt(resolved_cnt), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  // Reference: condition named per code, redirect/PC from the architectural rules
  function automatic res_t ref_eval(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic pred, input logic [31:0] tgt, input logic [31:0] fall,
                                    input logic [3:0] tag);
    res_t r;
    int   sa, sb;
    logic c, ill;
    sa = a; sb = b; c = 1'b0; ill = 1'b0;
    case (op)
      4'b0000: c = 1'b0;        4'b1000: c = 1'b1;
      4'b0001: c = (sa == sb);  4'b1001: c = (sa != sb);
      4'b0010: c = (sa <  sb);  4'b1010: c = (sa >= sb);
      4'b0011: c = (sa <= sb);  4'b1011: c = (sa >  sb);
      4'b0101: c = (sa == 0);   4'b1101: c = (sa != 0);
      4'b0110: c = (sa <  0);   4'b1110: c = (sa >= 0);
      4'b0111: c = (sa <= 0);   4'b1111: c = (sa >  0);
      default: ill = 1'b1;
    endcase
    r.cond     = c;
    r.illegal  = ill;
    r.redirect = ill ? pred : (c != pred);
    r.pc       = ill ? fall : (c ? tgt : fall);
    r.tag      = tag;
    return r;
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom % 5)
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return $urandom;
      default: return 32'($signed($urandom_range(0, 6)) - 3);
    endcase
  endfunction

  // Scoreboard: model occupancy, result order and counters evaluated away from the clock edge
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      mres = 0;
      mred = 0;
      last_in_hs = 1'b0;
    end else begin
      exp_rdy = !flush && (out_ready || q.size() < STAGES);
      vectors++;
      if (in_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL in_ready: got %b expected %b (held %0d) t=%0t", in_ready, exp_rdy, q.size(), $time);
      end
      vectors++;
      if (resolved_cnt !== CNTB'(mres) || redirect_cnt !== CNTB'(mred)) begin
        miscompares++;
        $display("FAIL counters: got %0d/%0d expected %0d/%0d t=%0t", resolved_cnt, redirect_cnt, mres, mred, $time);
      end
      ohs = 1'b0;
      if (out_valid !== 1'b0) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL spurious_out: out_valid=%b expected 0 t=%0t", out_valid, $time);
        end else begin
          exp_r = q[0];
          if ({out_cond, out_illegal, out_redirect, out_redirect_pc, out_tag} !==
              {exp_r.cond, exp_r.illegal, exp_r.redirect, exp_r.pc, exp_r.tag}) begin
            miscompares++;
            $display("FAIL result: got c=%b i=%b r=%b pc=%h tag=%h expected c=%b i=%b r=%b pc=%h tag=%h t=%0t",
                     out_cond, out_illegal, out_redirect, out_redirect_pc, out_tag,
                     exp_r.cond, exp_r.illegal, exp_r.redirect, exp_r.pc, exp_r.tag, $time);
          end
          ohs = out_ready && !flush;
        end
      end
      last_in_hs = in_valid && exp_rdy;
      if (stats_clr) begin
        mres = 0;
        mred = 0;
      end else if (ohs) begin
        mres = (mres == CMAX) ? CMAX : mres + 1;
        if (exp_r.redirect) mred = (mred == CMAX) ? CMAX : mred + 1;
      end
      if (ohs) void'(q.pop_front());
      if (flush) q.delete();
      else if (last_in_hs)
        q.push_back(ref_eval(in_op2, in_a, in_b, in_pred_taken, in_target, in_fallthru, in_tag));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_random(input logic [3:0] tag);
    in_op2        = 4'($urandom);
    in_a          = pick_val();
    in_b          = pick_val();
    in_pred_taken = 1'($urandom);
    in_target     = $urandom | 32'h1;
    in_fallthru   = $urandom | 32'h1;
    in_tag        = tag;
  endtask

  task automatic drain();
    in_valid = 1'b0; flush = 1'b0; stats_clr = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 12 && q.size() != 0; i++) next_cycle();
    next_cycle();
  endtask

  task automatic test_reset();
    repeat (2) next_cycle();
    vectors++;
    if ({out_valid, out_cond, out_illegal, out_redirect, out_redirect_pc, out_tag} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b pc=%h tag=%h expected all zero", out_valid, out_redirect_pc, out_tag);
    end
    vectors++;
    if (resolved_cnt !== '0 || redirect_cnt !== '0) begin
      miscompares++;
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", resolved_cnt, redirect_cnt);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_gt_example();
    stats_clr = 1'b1; next_cycle(); stats_clr = 1'b0;
    out_ready = 1'b1;
    in_op2 = 4'b1011; in_a = 32'd1; in_b = 32'hFFFF_FFFF; in_pred_taken = 1'b0;
    in_target = 32'h100; in_fallthru = 32'h44; in_tag = 4'h5; in_valid = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    vectors++;
    if (last_in_hs !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL gt_accept: got hs=%b out_valid=%b expected hs=1 out_valid=0", last_in_hs, out_valid);
    end
    next_cycle();
    vectors++;
    if ({out_valid, out_cond, out_illegal, out_redirect, out_redirect_pc, out_tag} !==
        {1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 4'h5}) begin
      miscompares++;
      $display("FAIL gt_result: got v=%b c=%b i=%b r=%b pc=%h tag=%h expected v=1 c=1 i=0 r=1 pc=100 tag=5",
               out_valid, out_cond, out_illegal, out_redirect, out_redirect_pc, out_tag);
    end
    next_cycle();
    vectors++;
    if (resolved_cnt !== 4'd1 || redirect_cnt !== 4'd1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL gt_counters: got %0d/%0d v=%b expected 1/1 v=0", resolved_cnt, redirect_cnt, out_valid);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] pa [4];
    logic [31:0] pb [4];
    int accepted;
    pa[0] = 32'hFFFF_FFFF; pb[0] = 32'h0;
    pa[1] = 32'h0;         pb[1] = 32'h0;
    pa[2] = 32'h1;         pb[2] = 32'h0;
    pa[3] = 32'h8000_0000; pb[3] = 32'h7FFF_FFFF;
    accepted = 0;
    out_ready = 1'b1;
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 16; c++) begin
        drive_random(4'(c));
        in_op2 = 4'(c); in_a = pa[p]; in_b = pb[p]; in_valid = 1'b1;
        next_cycle();
        if (last_in_hs) accepted++;
      end
    end
    drain();
    vectors++;
    if (accepted != 64 || q.size() != 0) begin
      miscompares++;
      $display("FAIL sweep_complete: got accepted=%0d pending=%0d expected 64/0", accepted, q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic pat [4];
    int   issued;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    issued = 0;
    drive_random(4'd0);
    for (int cyc = 0; cyc < 60 && issued < 8; cyc++) begin
      out_ready = pat[cyc % 4];
      in_valid  = 1'b1;
      next_cycle();
      if (last_in_hs) begin
        issued++;
        drive_random(4'(issued));
      end
    end
    drain();
    vectors++;
    if (issued != 8 || q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_complete: got issued=%0d pending=%0d expected 8/0", issued, q.size());
    end
  endtask

  task automatic fill_two();
    int n;
    n = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 6 && n < 2; i++) begin
      drive_random(4'(n + 3));
      in_valid = 1'b1;
      next_cycle();
      if (last_in_hs) n++;
    end
    in_valid = 1'b0;
    vectors++;
    if (n != 2 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fill: got n=%0d out_valid=%b in_ready=%b expected 2/1/0", n, out_valid, in_ready);
    end
  endtask

  task automatic test_flush();
    int sr, sd;
    fill_two();
    sr = mres; sd = mred;
    drive_random(4'hF);
    in_valid = 1'b1; flush = 1'b1;
    next_cycle();
    flush = 1'b0; in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || resolved_cnt !== CNTB'(sr) || redirect_cnt !== CNTB'(sd)) begin
      miscompares++;
      $display("FAIL flush_clear: got v=%b cnt=%0d/%0d expected v=0 cnt=%0d/%0d",
               out_valid, resolved_cnt, redirect_cnt, sr, sd);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_leak: got out_valid=%b tag=%h expected 0", out_valid, out_tag);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive_random(4'($urandom));
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 25) == 0;
      stats_clr = ($urandom % 40) == 0;
      next_cycle();
    end
    drain();
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL random_drain: got pending=%0d expected 0", q.size());
    end
  endtask

  task automatic test_async_reset();
    fill_two();
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({out_valid, out_cond, out_illegal, out_redirect, out_redirect_pc, out_tag} !== '0 ||
        resolved_cnt !== '0 || redirect_cnt !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got v=%b pc=%h tag=%h cnt=%0d/%0d expected all zero",
               out_valid, out_redirect_pc, out_tag, resolved_cnt, redirect_cnt);
    end
    #4;
    reset = 1'b0;
    next_cycle();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL async_recover: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_saturation();
    res_t r;
    int   lo;
    stats_clr = 1'b1; next_cycle(); stats_clr = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive_random(4'(i));
      lo = $urandom_range(0, 6);
      if (lo >= 4) lo++;
      in_op2 = {1'($urandom), 3'(lo)};
      r = ref_eval(in_op2, in_a, in_b, 1'b0, in_target, in_fallthru, in_tag);
      in_pred_taken = !r.cond;
      in_valid = 1'b1;
      next_cycle();
    end
    drain();
    vectors++;
    if (resolved_cnt !== 4'd15 || redirect_cnt !== 4'd15) begin
      miscompares++;
      $display("FAIL saturate: got %0d/%0d expected 15/15", resolved_cnt, redirect_cnt);
    end
    drive_random(4'h9);
    in_valid = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    next_cycle();
    stats_clr = 1'b1;
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_setup: got out_valid=%b expected 1", out_valid);
    end
    next_cycle();
    stats_clr = 1'b0;
    vectors++;
    if (resolved_cnt !== '0 || redirect_cnt !== '0) begin
      miscompares++;
      $display("FAIL clr_priority: got %0d/%0d expected 0/0", resolved_cnt, redirect_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_gt_example();
    test_sweep();
    test_back_to_back();
    test_flush();
    test_random();
    test_async_reset();
    test_saturation();
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
